// File: rtl/tt_pkg.sv
// Shared types and limits for the truth-table sweep checker.
package tt_pkg;

    localparam int LAT_MAX = 7;
    localparam int X_MAX_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Generic view of one in-flight check tag (valid flag plus stimulus vector)
    typedef struct packed {
        logic               valid;
        logic [X_MAX_W-1:0] x;
    } tag_t;

endpackage

// File: rtl/tt_tag_pipe.sv
// Delay line carrying (valid, x) check tags alongside the DUT pipeline.
// LAT=0 is a pure wire; flush drops every in-flight tag on the next edge.
module tt_tag_pipe
    import tt_pkg::*;
#(
    parameter int IN_W = 8,
    parameter int LAT  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            vld_i,
    input  logic [IN_W-1:0] x_i,
    output logic            vld_o,
    output logic [IN_W-1:0] x_o
);

    localparam int D = (LAT > LAT_MAX) ? LAT_MAX : LAT;

    generate
        if (D == 0) begin : g_comb
            logic unused_ok;
            assign unused_ok = &{1'b0, clk, rst_n, flush_i};
            assign vld_o     = vld_i;
            assign x_o       = x_i;
        end else begin : g_pipe
            logic [D-1:0]    vld_q;
            logic [IN_W-1:0] x_q [D];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= '0;
                end else if (flush_i) begin
                    vld_q <= '0;
                end else begin
                    vld_q[0] <= vld_i;
                    for (int i = 1; i < D; i++) vld_q[i] <= vld_q[i-1];
                end
            end

            // Vector bits are qualified by vld_q, so they need no reset
            always_ff @(posedge clk) begin
                x_q[0] <= x_i;
                for (int i = 1; i < D; i++) x_q[i] <= x_q[i-1];
            end

            assign vld_o = vld_q[D-1];
            assign x_o   = x_q[D-1];
        end
    endgenerate

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps every input vector into two implementations of one truth table and
// checks both against a loadable expected table, LAT cycles after each vector.
module tt_sweep_checker
    import tt_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 5,
    parameter int LAT   = 0,
    parameter int CNT_W = IN_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_tbl_we,
    input  logic [IN_W-1:0]  i_tbl_addr,
    input  logic [OUT_W-1:0] i_tbl_data,
    output logic [IN_W-1:0]  o_x,
    output logic             o_valid,
    input  logic [OUT_W-1:0] i_y_a,
    input  logic [OUT_W-1:0] i_y_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [IN_W-1:0]  o_ff_x,
    output logic [1:0]       o_ff_mask
);

    localparam int               DLY     = (LAT > LAT_MAX) ? LAT_MAX : LAT;
    localparam logic [IN_W-1:0]  X_LAST  = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [IN_W-1:0]  x_q, x_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [IN_W-1:0]  ffx_q, ffx_d;
    logic [1:0]       ffm_q, ffm_d;
    logic             done_q, done_d;
    logic [OUT_W-1:0] tbl_q [2**IN_W];

    logic             start_go, abort_go, tag_vld, cmp_go;
    logic [IN_W-1:0]  tag_x;
    logic [OUT_W-1:0] exp_y;
    logic [1:0]       mask;

    assign o_busy   = (state_q == RUN) || (state_q == DRAIN);
    assign o_valid  = (state_q == RUN);
    assign start_go = i_start && ((state_q == IDLE) || (state_q == DONE));
    assign abort_go = i_abort && o_busy;

    tt_tag_pipe #(
        .IN_W (IN_W),
        .LAT  (DLY)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (abort_go),
        .vld_i   (o_valid),
        .x_i     (x_q),
        .vld_o   (tag_vld),
        .x_o     (tag_x)
    );

    assign exp_y  = tbl_q[tag_x];
    assign mask   = {(i_y_b != exp_y), (i_y_a != exp_y)};
    assign cmp_go = tag_vld && !abort_go;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (i_start) state_d = RUN;
            RUN: begin
                if (i_abort)              state_d = IDLE;
                else if (x_q == X_LAST)   state_d = (DLY == 0) ? DONE : DRAIN;
            end
            DRAIN: begin
                if (i_abort)                          state_d = IDLE;
                else if (tag_vld && tag_x == X_LAST)  state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Done trails the final compare by one edge, so it is set from the DONE state
    always_comb begin
        x_d    = x_q;
        err_d  = err_q;
        ffx_d  = ffx_q;
        ffm_d  = ffm_q;
        done_d = done_q;
        if (start_go) begin
            x_d    = '0;
            err_d  = '0;
            ffx_d  = '0;
            ffm_d  = '0;
            done_d = 1'b0;
        end else begin
            if (state_q == RUN && !abort_go && x_q != X_LAST) x_d = x_q + 1'b1;
            if (state_q == DONE) done_d = 1'b1;
            if (cmp_go && mask != 2'b00) begin
                if (err_q != CNT_MAX) err_d = err_q + 1'b1;
                if (ffm_q == 2'b00) begin
                    ffx_d = tag_x;
                    ffm_d = mask;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            err_q   <= '0;
            ffx_q   <= '0;
            ffm_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            err_q   <= err_d;
            ffx_q   <= ffx_d;
            ffm_q   <= ffm_d;
            done_q  <= done_d;
        end
    end

    // Expected table keeps its contents across reset; frozen while a sweep runs
    always_ff @(posedge clk) begin
        if (i_tbl_we && !o_busy) tbl_q[i_tbl_addr] <= i_tbl_data;
    end

    assign o_x       = x_q;
    assign o_done    = done_q;
    assign o_pass    = done_q && (err_q == '0);
    assign o_err_cnt = err_q;
    assign o_ff_x    = ffx_q;
    assign o_ff_mask = ffm_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: three configurations (LAT=0, LAT=2, CNT_W=4) driven by
// directed sweeps, checked cycle-by-cycle against a sweep-level behavioural model.
module tb_tt_sweep_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] st, ab, we;
    logic [7:0] tbl_addr;
    logic [4:0] tbl_data;
    logic       mis;
    logic       fa [256];
    logic       fb [256];
    logic [4:0] sh_tbl [3][256];

    int checks = 0;
    int errors = 0;

    logic [7:0] x0, x2, x4, fx0, fx2, fx4;
    logic       v0, v2, v4, bz0, bz2, bz4, dn0, dn2, dn4, ps0, ps2, ps4;
    logic [8:0] ec0, ec2;
    logic [3:0] ec4;
    logic [1:0] fm0, fm2, fm4;
    logic [4:0] ya0, yb0, ya2, yb2, ya4, yb4;
    logic [4:0] ya2_p0, ya2_p1, yb2_p0, yb2_p1, ya2_c, yb2_c;

    function automatic logic [4:0] ref_f(input logic [7:0] x);
        logic [7:0] t;
        t = (x * 8'd13) ^ (x >> 3);
        return t[4:0];
    endfunction

    // Implementations under test: reference function with injectable single-bit faults
    always_comb begin
        ya0   = ref_f(x0) ^ {4'b0, fa[x0]};
        yb0   = ref_f(x0) ^ {4'b0, fb[x0]};
        ya4   = ref_f(x4) ^ {4'b0, fa[x4]};
        yb4   = ref_f(x4) ^ {4'b0, fb[x4]};
        ya2_c = ref_f(x2) ^ {4'b0, fa[x2]};
        yb2_c = ref_f(x2) ^ {4'b0, fb[x2]};
    end

    always @(posedge clk) begin
        ya2_p0 <= ya2_c;
        ya2_p1 <= ya2_p0;
        yb2_p0 <= yb2_c;
        yb2_p1 <= yb2_p0;
    end

    assign ya2 = mis ? ya2_c : ya2_p1;
    assign yb2 = mis ? yb2_c : yb2_p1;

    tt_sweep_checker #(.IN_W(8), .OUT_W(5), .LAT(0), .CNT_W(9)) u0 (
        .clk(clk), .rst_n(rst_n), .i_start(st[0]), .i_abort(ab[0]),
        .i_tbl_we(we[0]), .i_tbl_addr(tbl_addr), .i_tbl_data(tbl_data),
        .o_x(x0), .o_valid(v0), .i_y_a(ya0), .i_y_b(yb0),
        .o_busy(bz0), .o_done(dn0), .o_pass(ps0), .o_err_cnt(ec0),
        .o_ff_x(fx0), .o_ff_mask(fm0)
    );

    tt_sweep_checker #(.IN_W(8), .OUT_W(5), .LAT(2), .CNT_W(9)) u2 (
        .clk(clk), .rst_n(rst_n), .i_start(st[1]), .i_abort(ab[1]),
        .i_tbl_we(we[1]), .i_tbl_addr(tbl_addr), .i_tbl_data(tbl_data),
        .o_x(x2), .o_valid(v2), .i_y_a(ya2), .i_y_b(yb2),
        .o_busy(bz2), .o_done(dn2), .o_pass(ps2), .o_err_cnt(ec2),
        .o_ff_x(fx2), .o_ff_mask(fm2)
    );

    tt_sweep_checker #(.IN_W(8), .OUT_W(5), .LAT(0), .CNT_W(4)) u4 (
        .clk(clk), .rst_n(rst_n), .i_start(st[2]), .i_abort(ab[2]),
        .i_tbl_we(we[2]), .i_tbl_addr(tbl_addr), .i_tbl_data(tbl_data),
        .o_x(x4), .o_valid(v4), .i_y_a(ya4), .i_y_b(yb4),
        .o_busy(bz4), .o_done(dn4), .o_pass(ps4), .o_err_cnt(ec4),
        .o_ff_x(fx4), .o_ff_mask(fm4)
    );

    int         mon_inst = 0;
    int         mon_lat = 0;
    int         mon_cmax = 511;
    int         mon_n = 0;
    logic       mon_on = 1'b0;
    logic [7:0] obs_x, obs_fx;
    logic       obs_v, obs_bz, obs_dn, obs_ps;
    logic [8:0] obs_ec;
    logic [1:0] obs_fm;

    always_comb begin
        case (mon_inst)
            0: begin
                obs_x = x0; obs_v = v0; obs_bz = bz0; obs_dn = dn0; obs_ps = ps0;
                obs_ec = ec0; obs_fx = fx0; obs_fm = fm0;
            end
            1: begin
                obs_x = x2; obs_v = v2; obs_bz = bz2; obs_dn = dn2; obs_ps = ps2;
                obs_ec = ec2; obs_fx = fx2; obs_fm = fm2;
            end
            default: begin
                obs_x = x4; obs_v = v4; obs_bz = bz4; obs_dn = dn4; obs_ps = ps4;
                obs_ec = {5'b0, ec4}; obs_fx = fx4; obs_fm = fm4;
            end
        endcase
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Which implementations disagree with the expected table at vector v
    function automatic logic [1:0] fail_mask(input int inst, input int v);
        logic [7:0] vv;
        logic [4:0] e, a, b;
        vv = v[7:0];
        e  = sh_tbl[inst][vv];
        a  = ref_f(vv) ^ {4'b0, fa[vv]};
        b  = ref_f(vv) ^ {4'b0, fb[vv]};
        return {(b != e), (a != e)};
    endfunction

    // n = cycles since the start edge; vector v is judged once n > v + LAT
    task automatic monitor_cycle(input int n);
        int         cnt, ffx, ffm;
        logic [1:0] m;
        logic       exp_done;
        cnt = 0; ffx = 0; ffm = 0;
        for (int v = 0; v < 256 && v <= n - 1 - mon_lat; v++) begin
            m = fail_mask(mon_inst, v);
            if (m != 2'b00) begin
                if (cnt < mon_cmax) cnt++;
                if (ffm == 0) begin
                    ffx = v;
                    ffm = int'(m);
                end
            end
        end
        exp_done = (n >= 257 + mon_lat);
        chk("mon_valid", obs_v, n < 256);
        chk("mon_x", obs_x, (n < 256) ? n : 255);
        chk("mon_busy", obs_bz, n < 256 + mon_lat);
        chk("mon_done", obs_dn, exp_done);
        chk("mon_pass", obs_ps, exp_done && cnt == 0);
        chk("mon_err", obs_ec, cnt);
        chk("mon_ffx", obs_fx, ffx);
        chk("mon_ffmask", obs_fm, ffm);
    endtask

    always @(negedge clk) begin
        if (!mon_on) begin
            mon_n = 0;
        end else begin
            monitor_cycle(mon_n);
            mon_n++;
        end
    end

    task automatic load(input int inst, input logic inv);
        for (int v = 0; v < 256; v++) begin
            @(negedge clk);
            tbl_addr = v[7:0];
            tbl_data = inv ? ~ref_f(v[7:0]) : ref_f(v[7:0]);
            sh_tbl[inst][v] = tbl_data;
            we = 3'b001 << inst;
        end
        @(negedge clk);
        we = 3'b000;
    endtask

    task automatic sweep(input int inst, input int lat, input int cmax,
                         input logic use_mon, input int exp_edge);
        int   e;
        logic seen;
        @(negedge clk);
        mon_inst = inst;
        mon_lat  = lat;
        mon_cmax = cmax;
        st[inst] = 1'b1;
        @(posedge clk);
        #1 st[inst] = 1'b0;
        mon_on = use_mon;
        e = 0;
        seen = 1'b0;
        while (!seen && e < 400) begin
            @(posedge clk);
            #1 e++;
            if (obs_dn) seen = 1'b1;
        end
        chk("done_edge", e, exp_edge);
        repeat (2) @(posedge clk);
        #1 mon_on = 1'b0;
    endtask

    task automatic start_only(input int inst);
        @(negedge clk);
        mon_inst = inst;
        st[inst] = 1'b1;
        @(posedge clk);
        #1 st[inst] = 1'b0;
    endtask

    initial begin
        int e;
        st = '0; ab = '0; we = '0; tbl_addr = '0; tbl_data = '0; mis = 1'b0;
        for (int v = 0; v < 256; v++) begin
            fa[v] = 1'b0;
            fb[v] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x", x0, 0);
        chk("rst_valid", v0, 0);
        chk("rst_busy", bz0, 0);
        chk("rst_done", dn0, 0);
        chk("rst_pass", ps0, 0);
        chk("rst_err", ec0, 0);
        chk("rst_ffx", fx0, 0);
        chk("rst_ffmask", fm0, 0);
        rst_n = 1'b1;

        load(0, 1'b0);
        load(1, 1'b0);
        load(2, 1'b1);

        sweep(0, 0, 511, 1'b1, 257);
        chk("clean_pass", ps0, 1);
        chk("clean_err", ec0, 0);

        fb[8'h5A] = 1'b1;
        sweep(0, 0, 511, 1'b1, 257);
        chk("b5a_err", ec0, 1);
        chk("b5a_ffx", fx0, 8'h5A);
        chk("b5a_ffmask", fm0, 2'b10);
        chk("b5a_pass", ps0, 0);
        fb[8'h5A] = 1'b0;

        fa[8'h03] = 1'b1;
        fa[8'hF0] = 1'b1;
        sweep(1, 2, 511, 1'b1, 259);
        chk("lat2_err", ec2, 2);
        chk("lat2_ffx", fx2, 8'h03);
        chk("lat2_ffmask", fm2, 2'b01);
        chk("lat2_pass", ps2, 0);
        mis = 1'b1;
        sweep(1, 2, 511, 1'b0, 259);
        chk("misalign_err_nonzero", ec2 != 9'd0, 1);
        mis = 1'b0;
        fa[8'h03] = 1'b0;
        fa[8'hF0] = 1'b0;

        start_only(0);
        e = 0;
        while (x0 !== 8'h40 && e < 100) begin
            @(negedge clk);
            e++;
        end
        chk("abort_reached_40", e < 100, 1);
        ab[0] = 1'b1;
        @(posedge clk);
        #1 ab[0] = 1'b0;
        chk("abort_busy", bz0, 0);
        chk("abort_done", dn0, 0);
        chk("abort_valid", v0, 0);
        chk("abort_x_hold", x0, 8'h40);
        repeat (5) @(posedge clk);
        #1 chk("abort_done_later", dn0, 0);
        sweep(0, 0, 511, 1'b1, 257);
        chk("restart_pass", ps0, 1);

        fork
            sweep(0, 0, 511, 1'b1, 257);
            begin
                repeat (20) @(negedge clk);
                tbl_addr = 8'hF0;
                tbl_data = ~ref_f(8'hF0);
                we = 3'b001;
                @(negedge clk);
                we = 3'b000;
            end
        join
        chk("busy_write_ignored_pass", ps0, 1);
        chk("busy_write_ignored_err", ec0, 0);

        sweep(2, 0, 15, 1'b1, 257);
        chk("sat_err", ec4, 4'hF);
        chk("sat_ffx", fx4, 8'h00);
        chk("sat_ffmask", fm4, 2'b11);
        chk("sat_pass", ps4, 0);

        fb[8'h5A] = 1'b1;
        start_only(0);
        repeat (120) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_x", x0, 0);
        chk("midrst_valid", v0, 0);
        chk("midrst_busy", bz0, 0);
        chk("midrst_done", dn0, 0);
        chk("midrst_err", ec0, 0);
        chk("midrst_ffx", fx0, 0);
        chk("midrst_ffmask", fm0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        fb[8'h5A] = 1'b0;
        sweep(0, 0, 511, 1'b1, 257);
        chk("table_kept_pass", ps0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
